fp_addsub_ctrl: RTL and testbench

- Sequencing controller for the shared single-precision IEEE-754 add/subtract datapath in the multi-cycle core.
- Accepts one add or sub request at a time over a valid/ready handshake and registers the operands.
- Holds the operands stable to the instantiated ieee754_adder for a fixed multi-cycle window, then captures the result and exception flags into a response register.
- Accumulates sticky overflow/underflow flags for the FP CSR logic.

---
 rtl/fp_ctrl_pkg.sv | 29 ++
 rtl/ieee754_adder.sv | 108 ++++++++++
 rtl/fp_addsub_ctrl.sv | 135 +++++++++++++
 tb/tb_fp_addsub_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP add/sub sequencing controller: state and opcode
// encodings plus a few IEEE-754 single-precision constants.
package fp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } fp_state_e;

    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO  = 32'h4000_0000;
    localparam logic [31:0] FP_MAX  = 32'h7F7F_FFFF;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit mantissa; the highest set bit wins, 27 when empty.
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            n = v[i] ? 5'(26 - i) : n;
        end
        return n;
    endfunction

endpackage

// File: rtl/ieee754_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with overflow and tiny-result (underflow) indications.
module ieee754_adder
    import fp_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    logic        sa_s, sb_s, sl_s, ss_s, swap_s, eff_sub_s, up_s;
    logic [7:0]  ea_s, eb_s, el_s, es_s, d_s;
    logic [22:0] fa_s, fb_s, fl_s, fs_s, frac_s;
    logic [23:0] ml_s, ms_s;
    logic [4:0]  dcap_s, lz_s;
    logic [49:0] wide_s;
    logic [26:0] al_s, norm_s;
    logic [27:0] sum_s;
    logic [9:0]  exp_n_s, exp_f_s;
    logic [24:0] rnd_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s;

    // Align, add/subtract, normalise and round the two operands.
    always_comb begin
        sa_s = a[31];
        sb_s = b[31];
        ea_s = a[30:23];
        eb_s = b[30:23];
        fa_s = a[22:0];
        fb_s = b[22:0];
        a_nan_s = (ea_s == 8'hFF) && (fa_s != 23'd0);
        b_nan_s = (eb_s == 8'hFF) && (fb_s != 23'd0);
        a_inf_s = (ea_s == 8'hFF) && (fa_s == 23'd0);
        b_inf_s = (eb_s == 8'hFF) && (fb_s == 23'd0);

        swap_s = {eb_s, fb_s} > {ea_s, fa_s};
        sl_s = swap_s ? sb_s : sa_s;
        ss_s = swap_s ? sa_s : sb_s;
        fl_s = swap_s ? fb_s : fa_s;
        fs_s = swap_s ? fa_s : fb_s;
        // Denormals use exponent 1 with no hidden bit.
        el_s = swap_s ? ((eb_s == 8'd0) ? 8'd1 : eb_s) : ((ea_s == 8'd0) ? 8'd1 : ea_s);
        es_s = swap_s ? ((ea_s == 8'd0) ? 8'd1 : ea_s) : ((eb_s == 8'd0) ? 8'd1 : eb_s);
        ml_s = {(swap_s ? (eb_s != 8'd0) : (ea_s != 8'd0)), fl_s};
        ms_s = {(swap_s ? (ea_s != 8'd0) : (eb_s != 8'd0)), fs_s};

        d_s    = el_s - es_s;
        dcap_s = (d_s > 8'd31) ? 5'd31 : d_s[4:0];
        wide_s = {ms_s, 26'd0} >> dcap_s;
        al_s   = {wide_s[49:24], wide_s[23] | (|wide_s[22:0])};

        eff_sub_s = sl_s ^ ss_s;
        if (eff_sub_s) begin
            sum_s = {1'b0, ml_s, 3'b000} - {1'b0, al_s};
        end else begin
            sum_s = {1'b0, ml_s, 3'b000} + {1'b0, al_s};
        end

        lz_s = clz27(sum_s[26:0]);
        if (sum_s[27]) begin
            norm_s  = {sum_s[27:2], sum_s[1] | sum_s[0]};
            exp_n_s = {2'b00, el_s} + 10'd1;
        end else if ({3'b000, lz_s} < el_s) begin
            norm_s  = sum_s[26:0] << lz_s;
            exp_n_s = {2'b00, el_s} - {5'd0, lz_s};
        end else begin
            norm_s  = sum_s[26:0] << (el_s - 8'd1);
            exp_n_s = 10'd0;
        end

        up_s  = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s = {1'b0, norm_s[26:3]} + {24'd0, up_s};
        if (rnd_s[24]) begin
            exp_f_s = exp_n_s + 10'd1;
            frac_s  = rnd_s[23:1];
        end else if ((exp_n_s == 10'd0) && rnd_s[23]) begin
            exp_f_s = 10'd1;
            frac_s  = rnd_s[22:0];
        end else begin
            exp_f_s = exp_n_s;
            frac_s  = rnd_s[22:0];
        end
    end

    // Resolve special operands, exact zero and exponent overflow into the final word.
    always_comb begin
        result    = {sl_s, exp_f_s[7:0], frac_s};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
            result = FP_QNAN;
        end else if (a_inf_s) begin
            result = a;
        end else if (b_inf_s) begin
            result = b;
        end else if (sum_s == 28'd0) begin
            result = {sa_s & sb_s, 31'd0};
        end else if (exp_f_s >= 10'd255) begin
            result   = {sl_s, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else begin
            underflow = (exp_f_s == 10'd0) && (frac_s != 23'd0);
        end
    end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// Sequencing controller for the shared single-precision add/sub datapath:
// captures a request, holds operands for EXEC_CYCLES, registers the response.
module fp_addsub_ctrl
    import fp_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_overflow,
    output logic        resp_underflow,
    input  logic        flags_clr,
    output logic        sticky_of,
    output logic        sticky_uf,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fp_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r, b_r;
    logic [31:0]      sum_s;
    logic             of_s, uf_s;
    logic             accept_s, capture_s;
    logic             resp_valid_r, resp_of_r, resp_uf_r;
    logic [31:0]      resp_result_r;
    logic             sticky_of_r, sticky_uf_r;

    ieee754_adder u_adder (
        .a         (a_r),
        .b         (b_r),
        .result    (sum_s),
        .overflow  (of_s),
        .underflow (uf_s)
    );

    assign req_ready = ((state_r == ST_IDLE) || ((state_r == ST_DONE) && resp_ready)) && !flush;
    assign accept_s  = req_valid && req_ready;
    assign capture_s = (state_r == ST_EXEC) && (cnt_r == CNT_ZERO) && !flush;

    assign resp_valid     = resp_valid_r;
    assign resp_result    = resp_result_r;
    assign resp_overflow  = resp_of_r;
    assign resp_underflow = resp_uf_r;
    assign sticky_of      = sticky_of_r;
    assign sticky_uf      = sticky_uf_r;
    assign busy           = (state_r != ST_IDLE);

    // Main sequencer: accept, countdown, capture and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            resp_valid_r  <= 1'b0;
            resp_result_r <= 32'd0;
            resp_of_r     <= 1'b0;
            resp_uf_r     <= 1'b0;
        end else if (flush) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= req_a;
                        b_r     <= {req_b[31] ^ (req_op == FP_OP_SUB), req_b[30:0]};
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == CNT_ZERO) begin
                        resp_result_r <= sum_s;
                        resp_of_r     <= of_s;
                        resp_uf_r     <= uf_s;
                        resp_valid_r  <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (accept_s) begin
                        // Consumer drains the result while the next request loads.
                        a_r          <= req_a;
                        b_r          <= {req_b[31] ^ (req_op == FP_OP_SUB), req_b[30:0]};
                        cnt_r        <= CNT_LOAD;
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_EXEC;
                    end else if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= CNT_ZERO;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky exception flags: clear first, then OR in a coincident capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_of_r <= 1'b0;
            sticky_uf_r <= 1'b0;
        end else begin
            sticky_of_r <= (sticky_of_r & ~flags_clr) | (capture_s & of_s);
            sticky_uf_r <= (sticky_uf_r & ~flags_clr) | (capture_s & uf_s);
        end
    end

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed self-checking bench for fp_addsub_ctrl with EXEC_CYCLES = 2.
module tb_fp_addsub_ctrl;
    import fp_ctrl_pkg::*;

    logic        clk, rst_n, flush, req_valid, req_ready, req_op;
    logic [31:0] req_a, req_b, resp_result;
    logic        resp_valid, resp_ready, resp_overflow, resp_underflow;
    logic        flags_clr, sticky_of, sticky_uf, busy;
    int          checks = 0;
    int          errors = 0;

    fp_addsub_ctrl #(.EXEC_CYCLES(2), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_overflow  (resp_overflow),
        .resp_underflow (resp_underflow),
        .flags_clr      (flags_clr),
        .sticky_of      (sticky_of),
        .sticky_uf      (sticky_uf),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request and follow it to resp_valid, optionally pulsing flags_clr at capture.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic clr_at_capture, input string tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_valid_e0"}, 32'(resp_valid), 32'd0);
        tick();
        chk({tag, "_valid_e1"}, 32'(resp_valid), 32'd0);
        flags_clr = clr_at_capture;
        tick();
        flags_clr = 1'b0;
        chk({tag, "_valid_e2"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic ack(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ack_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = FP_OP_ADD;
        req_a = 32'd0; req_b = 32'd0; resp_ready = 1'b0; flags_clr = 1'b0;
        #2;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_sticky", {30'd0, sticky_of, sticky_uf}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(req_ready), 32'd1);

        issue(FP_OP_ADD, FP_ONE, FP_TWO, 1'b0, "add");
        chk("add_result", resp_result, 32'h4040_0000);
        chk("add_flags", {30'd0, resp_overflow, resp_underflow}, 32'd0);
        chk("add_sticky", {30'd0, sticky_of, sticky_uf}, 32'd0);
        ack("add");

        issue(FP_OP_SUB, 32'h4040_0000, FP_ONE, 1'b0, "sub");
        chk("sub_result", resp_result, 32'h4000_0000);
        ack("sub");

        issue(FP_OP_SUB, 32'h00C0_0000, 32'h0080_0000, 1'b0, "uf");
        chk("uf_result", resp_result, 32'h0040_0000);
        chk("uf_flags", {30'd0, resp_overflow, resp_underflow}, 32'd1);
        chk("uf_sticky", {30'd0, sticky_of, sticky_uf}, 32'd1);
        ack("uf");

        issue(FP_OP_ADD, FP_MAX, FP_MAX, 1'b0, "of");
        chk("of_result", resp_result, 32'h7F80_0000);
        chk("of_flag", 32'(resp_overflow), 32'd1);
        chk("of_sticky", 32'(sticky_of), 32'd1);
        ack("of");

        issue(FP_OP_ADD, FP_ONE, FP_TWO, 1'b0, "keep");
        chk("keep_flag", 32'(resp_overflow), 32'd0);
        chk("keep_sticky", {30'd0, sticky_of, sticky_uf}, 32'd3);
        ack("keep");

        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("clr_sticky", {30'd0, sticky_of, sticky_uf}, 32'd0);

        issue(FP_OP_ADD, FP_MAX, FP_MAX, 1'b1, "coinc");
        chk("coinc_sticky", {30'd0, sticky_of, sticky_uf}, 32'd2);
        ack("coinc");

        issue(FP_OP_ADD, FP_ONE, FP_TWO, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_result", resp_result, 32'h4040_0000);
            chk("bp_flags", {30'd0, resp_overflow, resp_underflow}, 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_op = FP_OP_SUB; req_a = 32'h4040_0000; req_b = FP_ONE;
        #1;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("b2b_valid_e0", 32'(resp_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        tick();
        chk("b2b_valid_e1", 32'(resp_valid), 32'd0);
        tick();
        chk("b2b_valid_e2", 32'(resp_valid), 32'd1);
        chk("b2b_result", resp_result, 32'h4000_0000);
        ack("b2b");

        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        req_valid = 1'b1; req_op = FP_OP_ADD; req_a = FP_MAX; req_b = FP_MAX;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_valid", 32'(resp_valid), 32'd0);
        tick();
        tick();
        chk("fl_valid_late", 32'(resp_valid), 32'd0);
        chk("fl_sticky", 32'(sticky_of), 32'd0);
        chk("fl_result_hold", resp_result, 32'h4000_0000);

        issue(FP_OP_ADD, FP_MAX, FP_MAX, 1'b0, "pre_rst");
        resp_ready = 1'b1;
        req_valid = 1'b1; req_op = FP_OP_ADD; req_a = FP_ONE; req_b = FP_TWO;
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result", resp_result, 32'd0);
        chk("arst_flags", {29'd0, resp_valid, resp_overflow, resp_underflow}, 32'd0);
        chk("arst_sticky", {30'd0, sticky_of, sticky_uf}, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        chk("arst_no_resp", 32'(resp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
